// File: rtl/tag_tx_ctrl.sv
// Transmit-side framing sequencer for the tag localisation link.
// Emits one frame as a positive/negative sync tone pair followed by
// NLOC_PER_SYNC locations of NSYMB tone symbols, as a DDS phase stream
// with a valid/ready handshake. Also drives the front-panel GPIO with the
// active location index and a sync trigger for antenna switching.
module tag_tx_ctrl #(
  parameter int PHASE_WIDTH   = 24,
  parameter int NSYMB_WIDTH   = 16,
  parameter int REG_WIDTH     = 12,
  parameter int NSYNCP        = 16384,
  parameter int NSYNCN        = 16384,
  parameter int NSIG          = 262144,
  parameter int NSYMB         = 1,
  parameter int NLOC_PER_SYNC = 3
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    run_tx,
  input  logic [PHASE_WIDTH-1:0]                  sync_ph_inc,
  input  logic [PHASE_WIDTH-1:0]                  symb_ph_inc,
  input  logic [PHASE_WIDTH-1:0]                  symb_ph_step,
  input  logic                                    tx_ready,
  output logic                                    tx_valid,
  output logic [PHASE_WIDTH-1:0]                  ph,
  output logic [1:0]                              tx_state,
  output logic                                    tx_trig,
  output logic [$clog2(NSYNCP+NSYNCN+1)-1:0]      nsync_count,
  output logic [$clog2(NSIG+1)-1:0]               sigN,
  output logic [NSYMB_WIDTH-1:0]                  symbN,
  output logic [$clog2(NLOC_PER_SYNC+1)-1:0]      loc_idx,
  output logic [REG_WIDTH-1:0]                    fp_gpio_out,
  output logic [REG_WIDTH-1:0]                    fp_gpio_ddr
);

  localparam int NSC_W = $clog2(NSYNCP+NSYNCN+1);
  localparam int SIG_W = $clog2(NSIG+1);
  localparam int LOC_W = $clog2(NLOC_PER_SYNC+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_TX   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] ph_q, ph_d;
  logic [NSC_W-1:0]       nsync_q, nsync_d;
  logic [SIG_W-1:0]       sig_q, sig_d;
  logic [NSYMB_WIDTH-1:0] symb_q, symb_d;
  logic [LOC_W-1:0]       loc_q, loc_d;
  logic                   valid_q, valid_d;
  logic                   trig_q, trig_d;
  logic [REG_WIDTH-1:0]   fp_q, fp_d;

  logic                   fire;
  logic [PHASE_WIDTH-1:0] symb_inc;

  assign fire = valid_q & tx_ready;

  // Per-symbol tone increment; combinational so it is correct on the first
  // sample of every symbol without a pipeline bubble.
  assign symb_inc = symb_ph_inc + PHASE_WIDTH'(symb_q) * symb_ph_step;

  // Next-state, phase and counter update; everything advances only on fire.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    ph_d    = ph_q;
    nsync_d = nsync_q;
    sig_d   = sig_q;
    symb_d  = symb_q;
    loc_d   = loc_q;

    case (state_q)
      S_IDLE: begin
        if (run_tx) begin
          state_d = S_SYNC;
          ph_d    = '0;
          nsync_d = '0;
          sig_d   = '0;
          symb_d  = '0;
          loc_d   = '0;
        end
      end

      S_SYNC: begin
        if (fire) begin
          if (nsync_q == NSC_W'(NSYNCP + NSYNCN - 1)) begin
            state_d = S_TX;
            ph_d    = '0;
            nsync_d = '0;
            sig_d   = '0;
            symb_d  = '0;
            loc_d   = '0;
          end else begin
            nsync_d = nsync_q + NSC_W'(1);
            // Positive tone ramps up, negative tone ramps back down.
            ph_d    = (nsync_q < NSC_W'(NSYNCP)) ? ph_q + sync_ph_inc
                                                 : ph_q - sync_ph_inc;
          end
        end
      end

      S_TX: begin
        if (fire) begin
          if (sig_q == SIG_W'(NSIG - 1)) begin
            sig_d = '0;
            ph_d  = '0;
            if (symb_q == NSYMB_WIDTH'(NSYMB - 1)) begin
              symb_d = '0;
              if (loc_q == LOC_W'(NLOC_PER_SYNC - 1)) begin
                // Frame end: run_tx only matters here, so frames never truncate.
                loc_d   = '0;
                state_d = run_tx ? S_SYNC : S_IDLE;
              end else begin
                loc_d = loc_q + LOC_W'(1);
              end
            end else begin
              symb_d = symb_q + NSYMB_WIDTH'(1);
            end
          end else begin
            sig_d = sig_q + SIG_W'(1);
            ph_d  = ph_q + symb_inc;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status and GPIO derived from the next state so they register glitch-free.
  always_comb begin
    valid_d = (state_d != S_IDLE);
    trig_d  = (state_d == S_SYNC);
    fp_d    = valid_d ? {trig_d, (REG_WIDTH-1)'(loc_d)} : '0;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      nsync_q <= '0;
      sig_q   <= '0;
      symb_q  <= '0;
      loc_q   <= '0;
      valid_q <= 1'b0;
      trig_q  <= 1'b0;
      fp_q    <= '0;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      state_q <= state_d;
      ph_q    <= ph_d;
      nsync_q <= nsync_d;
      sig_q   <= sig_d;
      symb_q  <= symb_d;
      loc_q   <= loc_d;
      valid_q <= valid_d;
      trig_q  <= trig_d;
      fp_q    <= fp_d;
    end
  end

  assign tx_valid    = valid_q;
  assign ph          = ph_q;
  assign tx_state    = state_q;
  assign tx_trig     = trig_q;
  assign nsync_count = nsync_q;
  assign sigN        = sig_q;
  assign symbN       = symb_q;
  assign loc_idx     = loc_q;
  assign fp_gpio_out = fp_q;
  assign fp_gpio_ddr = '1;

endmodule
